// File: rtl/booth_mul_arb_pkg.sv
// Shared types and constants for the Booth multiplier arbiter.
package booth_mul_arb_pkg;

  localparam int DEF_W    = 32;
  localparam int DEF_NREQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/booth_mul_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr_i+1 with wrap-around.
module rr_arbiter
  import booth_mul_arb_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  grant_id_o,
  output logic            any_o
);

  int             idx;
  logic [IDW-1:0] idx_b;

  always_comb begin
    grant_o    = '0;
    grant_id_o = '0;
    any_o      = 1'b0;
    idx        = 0;
    idx_b      = '0;
    // The slot just after the last winner has highest priority.
    for (int i = 1; i <= NREQ; i++) begin
      idx   = (int'(ptr_i) + i) % NREQ;
      idx_b = idx[IDW-1:0];
      if (!any_o && req_i[idx_b]) begin
        grant_o[idx_b] = 1'b1;
        grant_id_o     = idx_b;
        any_o          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one iterative signed multiplier among NREQ requesters (round-robin).
// Optional WAIT timeout is enabled by defining BOOTH_MUL_ARB_TIMEOUT_EN.
module booth_mul_arbiter
  import booth_mul_arb_pkg::*;
#(
  parameter  int NREQ    = DEF_NREQ,
  parameter  int W       = DEF_W,
  parameter  int TIMEOUT = 64,
  localparam int IDW     = $clog2(NREQ),
  localparam int PW      = prod_w(W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [PW-1:0]     rsp_result,
  output logic              rsp_err,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  output logic              mul_start,
  input  logic              mul_done,
  input  logic [PW-1:0]     mul_result,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; request transfers only in IDLE, response fields hold in RESP
  // until rsp_ready, and the controller never waits on itself.

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, gid_q;
  logic [W-1:0]    a_q, b_q, a_sel, b_sel;
  logic [PW-1:0]   res_q;
  logic            err_q;
  logic [NREQ-1:0] arb_grant;
  logic [IDW-1:0]  arb_id;
  logic            arb_any;
  logic            timeout_hit;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i      (req_valid),
    .ptr_i      (rr_ptr_q),
    .grant_o    (arb_grant),
    .grant_id_o (arb_id),
    .any_o      (arb_any)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (arb_grant[k]) begin
        a_sel = req_a[k*W +: W];
        b_sel = req_b[k*W +: W];
      end
    end
  end

`ifdef BOOTH_MUL_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt_q;

  // Counts completed WAIT cycles; ISSUE always precedes WAIT, so clear there.
  always_ff @(posedge clk) begin
    if (reset)                  to_cnt_q <= '0;
    else if (state_q == ST_ISSUE) to_cnt_q <= '0;
    else if (state_q == ST_WAIT)  to_cnt_q <= to_cnt_q + 1'b1;
  end

  assign timeout_hit = (state_q == ST_WAIT) && (to_cnt_q == TW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (arb_any) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (mul_done || timeout_hit) state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    mul_start = 1'b0;
    rsp_valid = 1'b0;
    busy      = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE:  req_ready = reset ? '0 : arb_grant;
      ST_ISSUE: mul_start = 1'b1;
      ST_RESP:  rsp_valid = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      gid_q    <= '0;
      rr_ptr_q <= IDW'(NREQ - 1);
      res_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && arb_any) begin
        a_q   <= a_sel;
        b_q   <= b_sel;
        gid_q <= arb_id;
      end
      // A done pulse coinciding with the timeout wins.
      if (state_q == ST_WAIT) begin
        if (mul_done) begin
          res_q <= mul_result;
          err_q <= 1'b0;
        end else if (timeout_hit) begin
          res_q <= '0;
          err_q <= 1'b1;
        end
      end
      if (state_q == ST_RESP && rsp_ready) rr_ptr_q <= gid_q;
    end
  end

  assign mul_a      = a_q;
  assign mul_b      = b_q;
  assign rsp_id     = gid_q;
  assign rsp_result = res_q;
  assign rsp_err    = err_q;
  assign dbg_state  = state_q;

endmodule
